seven_seg_scanner: RTL
======================

# seven_seg_scanner

Time-multiplexes the two 8-bit seven-segment patterns from the hex-to-seven-segment stage onto one shared segment bus with two digit enables. Drives the physical two-digit display. Patterns are double-buffered and committed only at frame boundaries, so the display never tears. A programmable blanking gap between digits suppresses ghosting.

## Interface
- TICKS_ON, default 4: cycles each digit is lit; legal range 1..65535.
- TICKS_BLANK, default 1: cycles of blanking after each digit; legal range 0..65535, where 0 removes the blank states.
- ACTIVE_LOW, default 0: when 1, Segments and Anode are inverted for common-anode hardware.
- Clock  in  1  rising-edge clock; the block's only clock.
- Reset  in  1  synchronous, active-high reset.
- SevenSegDig1  in  8  high-nibble digit pattern, bit7=dp, bits6..0=gfedcba.
- SevenSegDig2  in  8  low-nibble digit pattern, same encoding.
- Load  in  1  one-cycle strobe; captures both patterns.
- Segments  out  8  shared segment bus.
- Anode  out  2  digit enables; bit1 = Dig1 position, bit0 = Dig2 position.
- FrameStart  out  1  one-cycle pulse in the first cycle of each frame.
- Pending  out  1  a captured pattern pair is waiting for the next frame boundary.

## Operation
- FSM states: IDLE, SHOW1, BLANK1, SHOW2, BLANK2.
- Transition order:
  - IDLE lasts 1 cycle, then goes to SHOW1.
  - SHOW1 lasts TICKS_ON cycles, then goes to BLANK1.
  - BLANK1 lasts TICKS_BLANK cycles, then goes to SHOW2.
  - SHOW2 lasts TICKS_ON cycles, then goes to BLANK2.
  - BLANK2 lasts TICKS_BLANK cycles, then goes to SHOW1.
  - With TICKS_BLANK=0, SHOW1 goes directly to SHOW2, and SHOW2 goes directly to SHOW1.
- Dwell counter: 16-bit. It clears on every state change and counts to the parameter value minus 1.
- Frame boundary: any clock edge whose next state is SHOW1.
- Storage: staging registers Stage1/Stage2 and display registers Shadow1/Shadow2.
- Load=1 at a non-boundary edge:
  - Stage1/Stage2 capture the inputs.
  - Pending sets to 1.
  - A later Load before the boundary overwrites the staging registers; the last Load wins.
- At a boundary edge:
  - If Load=1, the inputs go directly into Shadow1/Shadow2, bypassing staging.
  - Otherwise, if Pending=1, the Stage values are copied into Shadow.
  - Pending clears to 0 in both cases.
- Output values, before polarity:
  - SHOW1: Segments=Shadow1, Anode=2'b10.
  - SHOW2: Segments=Shadow2, Anode=2'b01.
  - IDLE and BLANK states: Segments=8'h00, Anode=2'b00.
- Polarity: with ACTIVE_LOW=1, both Segments and Anode are bitwise inverted, so the off levels are 8'hFF and 2'b11.
- Reset (any cycle, including mid-frame):
  - State goes to IDLE and the counter to 0.
  - Shadow and Stage registers clear to 8'h00.
  - Pending=0 and FrameStart=0.
  - Segments and Anode go to their off levels.
  - Load is ignored while Reset=1.
- The block holds no arithmetic on the pattern data; patterns pass through bit-exact.

## Timing
- All outputs are registered and are computed from the next state on the same edge. The outputs in a cycle therefore always match that cycle's state.
- Frame period is 2×(TICKS_ON+TICKS_BLANK) cycles.
- Worked example with defaults; cycle 0 is the first cycle after Reset is released:
  - cycle 0: IDLE.
  - cycles 1–4: SHOW1, with FrameStart=1 in cycle 1.
  - cycle 5: BLANK1.
  - cycles 6–9: SHOW2.
  - cycle 10: BLANK2.
  - cycle 11: SHOW1, with FrameStart=1.
- Load-to-display latency:
  - Load sampled at a boundary edge appears in the following cycle.
  - Otherwise it appears at the first cycle of the next frame.
- Pending rises the cycle after a non-boundary Load and falls in the first SHOW1 cycle of the next frame.
- Anode never has both bits active at the same time. There is no Segments/Anode skew, because both come from the same edge.

## Test plan
- Reset held then released; Load with SevenSegDig1=0x66 and SevenSegDig2=0x6D in cycle 0 -> Segments=0x66 and Anode=10 in cycles 1–4; 0x00/00 in cycle 5; 0x6D/01 in cycles 6–9; off in cycle 10; FrameStart=1 in cycles 1 and 11; Pending stays 0.
- Continuing from the first scenario, Load 0x06/0x5B in cycle 3 -> cycles 3–10 still show 0x66/0x6D; Pending=1 in cycles 4–10 and 0 in cycle 11; cycles 11–14 show 0x06.
- Two Loads in one frame (0x7F/0x3F in cycle 2, then 0x4F/0x66 in cycle 7) -> next frame shows 0x4F then 0x66; 0x7F never appears.
- ACTIVE_LOW=1 with patterns 0x66/0x6D -> SHOW1 gives Segments=0x99, Anode=01; SHOW2 gives 0x92, Anode=10; blank gives 0xFF, Anode=11.
- TICKS_BLANK=0 and TICKS_ON=2 -> after IDLE, sequence is SHOW1, SHOW1, SHOW2, SHOW2, repeating; FrameStart every 4 cycles; Anode never 00 after cycle 0.
- Reset asserted for one cycle during SHOW2 while Pending=1 -> next cycle is IDLE with outputs off and Pending=0; the following frame shows 0x00 on both digits.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - two-digit seven-segment scanner with frame-synchronous pattern commit
module seven_seg_scanner #(
    parameter int unsigned TICKS_ON    = 4,
    parameter int unsigned TICKS_BLANK = 1,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] SevenSegDig1,
    input  logic [7:0] SevenSegDig2,
    input  logic       Load,
    output logic [7:0] Segments,
    output logic [1:0] Anode,
    output logic       FrameStart,
    output logic       Pending
);

    // Last dwell count of each lit/blank state; BLANK_LAST is unused when blanking is disabled.
    localparam logic [15:0] ON_LAST    = 16'(TICKS_ON - 1);
    localparam logic [15:0] BLANK_LAST = (TICKS_BLANK == 0) ? 16'd0 : 16'(TICKS_BLANK - 1);
    localparam bit          NO_BLANK   = (TICKS_BLANK == 0);

    // XOR masks that turn logical levels into pin levels; also the pin "off" levels.
    localparam logic [7:0] SEG_POL = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [1:0] AN_POL  = ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHOW1  = 3'd1,
        BLANK1 = 3'd2,
        SHOW2  = 3'd3,
        BLANK2 = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  stage1_q, stage1_d;
    logic [7:0]  stage2_q, stage2_d;
    logic [7:0]  shadow1_q, shadow1_d;
    logic [7:0]  shadow2_q, shadow2_d;
    logic        pending_q, pending_d;
    logic        frame_start_q, frame_start_d;
    logic [7:0]  seg_q, seg_d;
    logic [1:0]  anode_q, anode_d;
    logic        boundary;

    // Next state and dwell counter: leave a state once its counter reaches its last tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = SHOW1;
            SHOW1:   if (cnt_q == ON_LAST)    state_d = NO_BLANK ? SHOW2 : BLANK1;
            BLANK1:  if (cnt_q == BLANK_LAST) state_d = SHOW2;
            SHOW2:   if (cnt_q == ON_LAST)    state_d = NO_BLANK ? SHOW1 : BLANK2;
            BLANK2:  if (cnt_q == BLANK_LAST) state_d = SHOW1;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end

    // Double buffering: staging absorbs loads mid-frame, shadow only changes on entry to SHOW1.
    always_comb begin
        boundary      = (state_d == SHOW1) && (state_q != SHOW1);
        stage1_d      = stage1_q;
        stage2_d      = stage2_q;
        shadow1_d     = shadow1_q;
        shadow2_d     = shadow2_q;
        pending_d     = pending_q;
        frame_start_d = boundary;
        if (boundary) begin
            pending_d = 1'b0;
            if (Load) begin
                shadow1_d = SevenSegDig1;
                shadow2_d = SevenSegDig2;
            end else if (pending_q) begin
                shadow1_d = stage1_q;
                shadow2_d = stage2_q;
            end
        end else if (Load) begin
            stage1_d  = SevenSegDig1;
            stage2_d  = SevenSegDig2;
            pending_d = 1'b1;
        end
    end

    // Pin levels derived from the next state so outputs line up with the state they belong to.
    always_comb begin
        seg_d   = 8'h00;
        anode_d = 2'b00;
        case (state_d)
            SHOW1: begin
                seg_d   = shadow1_d;
                anode_d = 2'b10;
            end
            SHOW2: begin
                seg_d   = shadow2_d;
                anode_d = 2'b01;
            end
            default: begin
                seg_d   = 8'h00;
                anode_d = 2'b00;
            end
        endcase
        seg_d   = seg_d ^ SEG_POL;
        anode_d = anode_d ^ AN_POL;
    end

    // All state and outputs register here; reset forces IDLE and the dark display.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= 16'd0;
            stage1_q      <= 8'h00;
            stage2_q      <= 8'h00;
            shadow1_q     <= 8'h00;
            shadow2_q     <= 8'h00;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_POL;
            anode_q       <= AN_POL;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage1_q      <= stage1_d;
            stage2_q      <= stage2_d;
            shadow1_q     <= shadow1_d;
            shadow2_q     <= shadow2_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            anode_q       <= anode_d;
        end
    end

    assign Segments   = seg_q;
    assign Anode      = anode_q;
    assign FrameStart = frame_start_q;
    assign Pending    = pending_q;

endmodule
